// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - Moore FSM sequencing register-file and ALU control for a small datapath
module alu_sequencer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        s,
    input  logic [15:0] instr,
    output logic        w,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        write,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  vsel,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop,
    output logic [15:0] sximm8,
    output logic        err
);

    typedef enum logic [2:0] {
        S_WAIT,
        S_GET_A,
        S_GET_B,
        S_EXEC,
        S_WRITE,
        S_WRITE_IMM,
        S_ERR
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] ir;
    logic        accept;
    logic        ir_is_mov;
    logic        ir_is_cmp;

    // Decode on {opcode, op}; the live instr is decoded because IR is not yet loaded on the accept edge.
    function automatic state_t decode(input logic [4:0] opc_op);
        case (opc_op)
            5'b110_10:                      decode = S_WRITE_IMM;
            5'b110_00:                      decode = S_GET_B;
            5'b101_00, 5'b101_01, 5'b101_10: decode = S_GET_A;
            5'b101_11:                      decode = S_GET_B;
            default:                        decode = S_ERR;
        endcase
    endfunction

    assign accept    = (state == S_WAIT) && s;
    assign ir_is_mov = (ir[15:13] == 3'b110);
    assign ir_is_cmp = (ir[15:11] == 5'b101_01);
    assign sximm8    = {{8{ir[7]}}, ir[7:0]};
    assign bsel      = 1'b0;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_WAIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Instruction register: captured only on accept, so instr is a don't-care mid-sequence.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ir <= 16'h0000;
        end else if (accept) begin
            ir <= instr;
        end
    end

    // Sticky error flag: cleared by any accept, set when leaving ERR.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err <= 1'b0;
        end else if (accept) begin
            err <= 1'b0;
        end else if (state == S_ERR) begin
            err <= 1'b1;
        end
    end

    // Next-state and Moore outputs from state and IR.
    always_comb begin
        state_nxt = state;
        w         = 1'b0;
        readnum   = 3'd0;
        writenum  = 3'd0;
        write     = 1'b0;
        loada     = 1'b0;
        loadb     = 1'b0;
        loadc     = 1'b0;
        loads     = 1'b0;
        asel      = 1'b0;
        vsel      = 2'b00;
        shift     = 2'b00;
        ALUop     = 2'b00;
        case (state)
            S_WAIT: begin
                w = 1'b1;
                if (s) begin
                    state_nxt = decode(instr[15:11]);
                end
            end
            S_GET_A: begin
                readnum   = ir[10:8];
                loada     = 1'b1;
                state_nxt = S_GET_B;
            end
            S_GET_B: begin
                readnum   = ir[2:0];
                loadb     = 1'b1;
                shift     = ir[4:3];
                state_nxt = S_EXEC;
            end
            S_EXEC: begin
                shift = ir[4:3];
                ALUop = ir_is_mov ? 2'b00 : ir[12:11];
                // MOV reg and MVN pass only B through the ALU, so A is forced to zero.
                asel  = ir_is_mov || (ir[12:11] == 2'b11);
                if (ir_is_cmp) begin
                    loads     = 1'b1;
                    state_nxt = S_WAIT;
                end else begin
                    loadc     = 1'b1;
                    state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                writenum  = ir[7:5];
                write     = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WRITE_IMM: begin
                vsel      = 2'b10;
                writenum  = ir[10:8];
                write     = 1'b1;
                state_nxt = S_WAIT;
            end
            S_ERR: begin
                state_nxt = S_WAIT;
            end
            default: begin
                state_nxt = S_WAIT;
            end
        endcase
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - scoreboard bench for alu_sequencer using directed instructions
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        s = 1'b0;
    logic [15:0] instr = 16'h0000;
    logic        w;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        asel;
    logic        bsel;
    logic [1:0]  vsel;
    logic [1:0]  shift;
    logic [1:0]  ALUop;
    logic [15:0] sximm8;
    logic        err;

    int total = 0;
    int bad = 0;

    typedef struct {
        string       nm;
        logic [36:0] v;
    } exp_t;

    exp_t q[$];

    alu_sequencer dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .s        (s),
        .instr    (instr),
        .w        (w),
        .readnum  (readnum),
        .writenum (writenum),
        .write    (write),
        .loada    (loada),
        .loadb    (loadb),
        .loadc    (loadc),
        .loads    (loads),
        .asel     (asel),
        .bsel     (bsel),
        .vsel     (vsel),
        .shift    (shift),
        .ALUop    (ALUop),
        .sximm8   (sximm8),
        .err      (err)
    );

    always #5 clk = ~clk;

    // Expected output vector; strobes st = {write, loada, loadb, loadc, loads}, bsel always 0.
    function automatic logic [36:0] ev(input logic w_e, input logic [2:0] rn, input logic [2:0] wn,
                                       input logic [4:0] st, input logic as, input logic [1:0] vs,
                                       input logic [1:0] sh, input logic [1:0] alu,
                                       input logic [15:0] imm, input logic er);
        return {w_e, rn, wn, st, as, 1'b0, vs, sh, alu, imm, er};
    endfunction

    localparam logic [36:0] Z = {1'b1, 36'd0};

    // One clock: drive inputs after the falling edge, expect the state after the next rising edge.
    task automatic step(input logic rst, input logic sv, input logic [15:0] iv,
                        input string nm, input logic [36:0] e);
        exp_t it;
        @(negedge clk);
        it.nm = nm;
        it.v  = e;
        q.push_back(it);
        reset_n = rst;
        s       = sv;
        instr   = iv;
    endtask

    // Asynchronous reset assertion between clock edges.
    task automatic async_rst(input string nm);
        exp_t it;
        @(negedge clk);
        it.nm = nm;
        it.v  = Z;
        q.push_back(it);
        s       = 1'b0;
        reset_n = 1'b0;
    endtask

    // Monitor: compare after every rising edge and on reset assertion.
    initial begin
        exp_t        it;
        logic [36:0] got;
        forever begin
            @(posedge clk or negedge reset_n);
            #1;
            if (q.size() > 0) begin
                it  = q.pop_front();
                got = {w, readnum, writenum, write, loada, loadb, loadc, loads,
                       asel, bsel, vsel, shift, ALUop, sximm8, err};
                total++;
                if (got !== it.v) begin
                    bad++;
                    $display("FAIL %s got=%h exp=%h", it.nm, got, it.v);
                end
                total++;
                if ($countones({write, loada, loadb, loadc, loads}) > 1) begin
                    bad++;
                    $display("FAIL %s_onehot got=%b exp=at_most_one",
                             it.nm, {write, loada, loadb, loadc, loads});
                end
            end
        end
    end

    initial begin
        int waited;
        step(0, 0, 16'h0000, "rst0", Z);
        step(0, 0, 16'h0000, "rst1", Z);
        step(1, 0, 16'h0000, "idle", Z);

        // MOV R0,#5
        step(1, 1, 16'hD005, "movi_wr",   ev(0, 0, 0, 5'b10000, 0, 2'b10, 0, 0, 16'h0005, 0));
        step(1, 0, 16'h0000, "movi_wait", ev(1, 0, 0, 5'b00000, 0, 0, 0, 0, 16'h0005, 0));

        // ADD R2,R1,R0 LSL1 with junk on instr and s mid-sequence
        step(1, 1, 16'hA148, "add_ga",   ev(0, 1, 0, 5'b01000, 0, 0, 2'b00, 0, 16'h0048, 0));
        step(1, 1, 16'hFFFF, "add_gb",   ev(0, 0, 0, 5'b00100, 0, 0, 2'b01, 0, 16'h0048, 0));
        step(1, 1, 16'hFFFF, "add_ex",   ev(0, 0, 0, 5'b00010, 0, 0, 2'b01, 2'b00, 16'h0048, 0));
        step(1, 1, 16'hFFFF, "add_wr",   ev(0, 0, 2, 5'b10000, 0, 0, 0, 0, 16'h0048, 0));
        step(1, 0, 16'hFFFF, "add_wait", ev(1, 0, 0, 5'b00000, 0, 0, 0, 0, 16'h0048, 0));

        // CMP R1,R0
        step(1, 1, 16'hA900, "cmp_ga",   ev(0, 1, 0, 5'b01000, 0, 0, 0, 0, 16'h0000, 0));
        step(1, 0, 16'h0000, "cmp_gb",   ev(0, 0, 0, 5'b00100, 0, 0, 0, 0, 16'h0000, 0));
        step(1, 0, 16'h0000, "cmp_ex",   ev(0, 0, 0, 5'b00001, 0, 0, 0, 2'b01, 16'h0000, 0));
        step(1, 0, 16'h0000, "cmp_wait", ev(1, 0, 0, 5'b00000, 0, 0, 0, 0, 16'h0000, 0));

        // AND R5,R2,R3 (negative imm8 field)
        step(1, 1, 16'hB2A3, "and_ga",   ev(0, 2, 0, 5'b01000, 0, 0, 0, 0, 16'hFFA3, 0));
        step(1, 0, 16'h0000, "and_gb",   ev(0, 3, 0, 5'b00100, 0, 0, 0, 0, 16'hFFA3, 0));
        step(1, 0, 16'h0000, "and_ex",   ev(0, 0, 0, 5'b00010, 0, 0, 0, 2'b10, 16'hFFA3, 0));
        step(1, 0, 16'h0000, "and_wr",   ev(0, 0, 5, 5'b10000, 0, 0, 0, 0, 16'hFFA3, 0));
        step(1, 0, 16'h0000, "and_wait", ev(1, 0, 0, 5'b00000, 0, 0, 0, 0, 16'hFFA3, 0));

        // MOV R2,R2 ASR-style shift 10
        step(1, 1, 16'hC052, "movr_gb",   ev(0, 2, 0, 5'b00100, 0, 0, 2'b10, 0, 16'h0052, 0));
        step(1, 0, 16'h0000, "movr_ex",   ev(0, 0, 0, 5'b00010, 1, 0, 2'b10, 2'b00, 16'h0052, 0));
        step(1, 0, 16'h0000, "movr_wr",   ev(0, 0, 2, 5'b10000, 0, 0, 0, 0, 16'h0052, 0));
        step(1, 0, 16'h0000, "movr_wait", ev(1, 0, 0, 5'b00000, 0, 0, 0, 0, 16'h0052, 0));

        // MVN R3,R1 then MOV R1,#-16 with s held high: one WAIT cycle between
        step(1, 1, 16'hB861, "mvn_gb",     ev(0, 1, 0, 5'b00100, 0, 0, 0, 0, 16'h0061, 0));
        step(1, 1, 16'hB861, "mvn_ex",     ev(0, 0, 0, 5'b00010, 1, 0, 0, 2'b11, 16'h0061, 0));
        step(1, 1, 16'hB861, "mvn_wr",     ev(0, 0, 3, 5'b10000, 0, 0, 0, 0, 16'h0061, 0));
        step(1, 1, 16'hD1F0, "b2b_wait",   ev(1, 0, 0, 5'b00000, 0, 0, 0, 0, 16'h0061, 0));
        step(1, 1, 16'hD1F0, "movi2_wr",   ev(0, 0, 1, 5'b10000, 0, 2'b10, 0, 0, 16'hFFF0, 0));
        step(1, 0, 16'h0000, "movi2_wait", ev(1, 0, 0, 5'b00000, 0, 0, 0, 0, 16'hFFF0, 0));

        // Illegal instructions and sticky err
        step(1, 1, 16'h0000, "err_state",  ev(0, 0, 0, 5'b00000, 0, 0, 0, 0, 16'h0000, 0));
        step(1, 0, 16'h0000, "err_set",    ev(1, 0, 0, 5'b00000, 0, 0, 0, 0, 16'h0000, 1));
        step(1, 0, 16'h0000, "err_hold",   ev(1, 0, 0, 5'b00000, 0, 0, 0, 0, 16'h0000, 1));
        step(1, 1, 16'hC8AA, "err2_state", ev(0, 0, 0, 5'b00000, 0, 0, 0, 0, 16'hFFAA, 0));
        step(1, 0, 16'h0000, "err2_set",   ev(1, 0, 0, 5'b00000, 0, 0, 0, 0, 16'hFFAA, 1));
        step(1, 1, 16'hD005, "err_clr",    ev(0, 0, 0, 5'b10000, 0, 2'b10, 0, 0, 16'h0005, 0));
        step(1, 0, 16'h0000, "clr_wait",   ev(1, 0, 0, 5'b00000, 0, 0, 0, 0, 16'h0005, 0));

        // Reset pulsed during EXEC of ADD: no write, immediate clear
        step(1, 1, 16'hA148, "rs_ga", ev(0, 1, 0, 5'b01000, 0, 0, 2'b00, 0, 16'h0048, 0));
        step(1, 0, 16'h0000, "rs_gb", ev(0, 0, 0, 5'b00100, 0, 0, 2'b01, 0, 16'h0048, 0));
        step(1, 0, 16'h0000, "rs_ex", ev(0, 0, 0, 5'b00010, 0, 0, 2'b01, 2'b00, 16'h0048, 0));
        async_rst("rs_async");
        step(0, 0, 16'h0000, "rs_hold", Z);
        step(1, 1, 16'hD005, "rs_movi", ev(0, 0, 0, 5'b10000, 0, 2'b10, 0, 0, 16'h0005, 0));
        step(1, 0, 16'h0000, "rs_wait", ev(1, 0, 0, 5'b00000, 0, 0, 0, 0, 16'h0005, 0));

        waited = 0;
        while (q.size() > 0 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        total++;
        if (q.size() > 0) begin
            bad++;
            $display("FAIL drain got=%0d exp=0 pending", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The block SHALL have ports: clk  in  1  rising-edge clock.
REQ-002 reset_n  in  1  asynchronous, active-low reset.
REQ-003 s  in  1  start request; sampled only while w=1.
REQ-004 instr  in  16  instruction: [15:13] opcode, [12:11] op, [10:8] Rn, [7:5] Rd, [4:3] shift, [2:0] Rm, [7:0] imm8.
REQ-005 w  out  1  idle/ready; high only in WAIT.
REQ-006 readnum  out  3; writenum  out  3; write  out  1: register-file controls.
REQ-007 loada, loadb, loadc, loads  out  1 each: A, B, C and status register load strobes.
REQ-008 asel, bsel  out  1 each: 1 forces ALU A input to 0 / B input to sximm5 (bsel is always 0 in this block).
REQ-009 vsel  out  2: write-back source, 2'b00 = C register, 2'b10 = sximm8.
REQ-010 shift  out  2; ALUop  out  2 (00 add, 01 sub, 10 and, 11 not-B).
REQ-011 sximm8  out  16: sign-extended IR[7:0].
REQ-012 err  out  1: sticky illegal-instruction flag.

Function
REQ-013 The block SHALL be a Moore FSM with states WAIT, GET_A, GET_B, EXEC, WRITE, WRITE_IMM, ERR; all outputs derive from state plus internal instruction register IR.
REQ-014 In WAIT with s=1, the rising edge SHALL latch instr into IR, clear err, and transition per decode of instr (not IR).
REQ-015 Decode: 110/10 MOV imm -> WRITE_IMM; 110/00 MOV reg -> GET_B; 101/00 ADD, 101/01 CMP, 101/10 AND -> GET_A; 101/11 MVN -> GET_B; anything else -> ERR.
REQ-016 GET_A: readnum=Rn, loada=1; next GET_B.
REQ-017 GET_B: readnum=Rm, loadb=1, shift=IR shift field; next EXEC.
REQ-018 EXEC: ALUop=IR op for 101 opcodes and 00 for MOV reg; asel=1 for MOV reg and MVN, else 0; shift=IR shift field.
REQ-019 EXEC with CMP: loads=1, loadc=0, next WAIT; otherwise loadc=1, loads=0, next WRITE.
REQ-020 WRITE: vsel=00, writenum=Rd, write=1; next WAIT.
REQ-021 WRITE_IMM: vsel=10, writenum=Rn, write=1; next WAIT.
REQ-022 ERR: err set on exit, all strobes 0; next WAIT.
REQ-023 Latency from accept edge to return to WAIT SHALL be: MOV imm 1, CMP/MVN/MOV reg 3, ADD/AND 4 cycles.
REQ-024 In WAIT and ERR, write, loada, loadb, loadc, loads SHALL be 0; readnum, writenum, shift, ALUop, vsel, asel, bsel SHALL be 0 in every state that does not define them.
REQ-025 s and instr SHALL be ignored outside WAIT; instr changes mid-sequence SHALL not affect outputs.
REQ-026 s held high SHALL accept a new instruction on the first WAIT edge, giving back-to-back execution with exactly one WAIT cycle between.
REQ-027 At most one of write, loada, loadb, loadc, loads SHALL be high in any cycle.

Reset
REQ-028 reset_n=0 SHALL immediately (asynchronously) force state WAIT, IR=16'h0000, err=0, w=1, all other outputs 0, including mid-sequence.
REQ-029 After reset_n deasserts, the first rising edge with s=1 SHALL accept an instruction normally.

Verification
REQ-030 Reset, then s=1 with instr=16'hD005 (MOV R0,#5) -> next cycle WRITE_IMM: writenum=0, vsel=10, sximm8=16'h0005, write=1; following cycle w=1.
REQ-031 instr=16'hA148 (ADD R2,R1,R0 LSL1) -> GET_A readnum=1 loada; GET_B readnum=0 loadb shift=01; EXEC ALUop=00 loadc; WRITE writenum=2 write; w=1 after 4 cycles.
REQ-032 instr=16'hA900 (CMP R1,R0) -> EXEC ALUop=01, loads=1, loadc=0; no write cycle; w=1 after 3 cycles.
REQ-033 instr=16'hB861 (MVN R3,R1) -> GET_B readnum=1; EXEC asel=1, ALUop=11; WRITE writenum=3; instr=16'hD1F0 -> sximm8=16'hFFF0, writenum=1.
REQ-034 instr=16'h0000 -> ERR one cycle, then w=1, err=1; next accepted legal instruction clears err.
REQ-035 reset_n pulsed low during EXEC of 16'hA148 -> write never asserts, outputs 0 within the reset pulse, w=1.
